// File: rtl/functional_lane_pkg.sv
// Shared lane types, widths and the single-cycle ALU helper.
package functional_lane_pkg;

  localparam int VECTOR_REG_WIDTH  = 64;
  localparam int ADDR_FIELD_WIDTH  = 5;
  localparam int NUM_OF_VECTOR_REG = 32;
  localparam int NUM_OF_LANES      = 4;
  localparam int VREG_IDX_WIDTH    = $clog2(NUM_OF_VECTOR_REG);
  localparam int ACCESS_LEN_WIDTH  = 8;

  // 3-bit encoding leaves spare codes; those decode as SADD.
  typedef enum logic [2:0] {
    SADD = 3'd0,
    SSUB = 3'd1,
    SMUL = 3'd2,
    SDIV = 3'd3
  } function_opcode_t;

  typedef enum logic {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } access_type_t;

  typedef enum logic {
    NON_STRIDE = 1'b0,
    STRIDE     = 1'b1
  } stride_type_t;

  typedef struct packed {
    logic                          vld;
    access_type_t                  access_type;
    logic [ACCESS_LEN_WIDTH-1:0]   access_length;
    stride_type_t                  stride_type;
    logic [VREG_IDX_WIDTH-1:0]     vec_reg_ptr;
    logic [ADDR_FIELD_WIDTH-1:0]   addr;
    logic [VECTOR_REG_WIDTH-1:0]   data;
  } cntrl_req_t;

  function automatic logic [VECTOR_REG_WIDTH-1:0] lane_alu(
    input function_opcode_t              op,
    input logic [VECTOR_REG_WIDTH-1:0]   a,
    input logic [VECTOR_REG_WIDTH-1:0]   b
  );
    case (op)
      SSUB:    lane_alu = a - b;
      SMUL:    lane_alu = a * b;
      default: lane_alu = a + b;
    endcase
  endfunction

endpackage

// File: rtl/functional_lane_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, W cycles per divide.
module lane_divider
  import functional_lane_pkg::*;
#(
  parameter int W = VECTOR_REG_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [W:0]    rem_sh;
  logic [W:0]    diff;
  logic          ge;

  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    // A zero divisor always "fits", which yields the all-ones quotient.
    ge     = (rem_sh >= {1'b0, dvs_q});
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = CW'(W);
      run_d = 1'b1;
    end else if (run_q) begin
      if (ge) begin
        rem_d = diff[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  // done flags the final step; quotient presents that step's result.
  assign done     = run_q && (cnt_q == CW'(1));
  assign quotient = quo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/functional_lane.sv
// One vector execution lane: add/sub/mul/div with a single write-back request.
module functional_lane
  import functional_lane_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vld,
  input  logic [VECTOR_REG_WIDTH-1:0]   data0,
  input  logic [VECTOR_REG_WIDTH-1:0]   data1,
  input  logic [VREG_IDX_WIDTH-1:0]     vec_reg_in,
  input  logic [ADDR_FIELD_WIDTH-1:0]   vec_addr,
  input  function_opcode_t              functional_opcode,
  output logic                          busy,
  output cntrl_req_t                    wr_req,
  input  logic                          wr_grant
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  logic [1:0]                    state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [VECTOR_REG_WIDTH-1:0]   a_q, a_d;
  logic [VECTOR_REG_WIDTH-1:0]   b_q, b_d;
  logic [VREG_IDX_WIDTH-1:0]     reg_q, reg_d;
  logic [ADDR_FIELD_WIDTH-1:0]   addr_q, addr_d;
  function_opcode_t              op_q, op_d;
  cntrl_req_t                    wr_req_q, wr_req_d;
  logic                          div_start;
  logic                          div_done;
  logic [VECTOR_REG_WIDTH-1:0]   div_quotient;

  lane_divider #(.W(VECTOR_REG_WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (reset),
    .start    (div_start),
    .dividend (data0),
    .divisor  (data1),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    reg_d     = reg_q;
    addr_d    = addr_q;
    op_d      = op_q;
    wr_req_d  = wr_req_q;
    div_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (vld) begin
          a_d    = data0;
          b_d    = data1;
          reg_d  = vec_reg_in;
          addr_d = vec_addr;
          op_d   = functional_opcode;
          if (functional_opcode == SDIV) begin
            div_start = 1'b1;
            state_d   = S_DIV;
          end else begin
            // EXEC runs cnt+1 cycles: one for add/sub, MUL_LATENCY for mul.
            cnt_d   = (functional_opcode == SMUL) ? CNT_W'(MUL_LATENCY - 1) : '0;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d                = S_WB;
          wr_req_d.vld           = 1'b1;
          wr_req_d.access_type   = WRITE_REQ;
          wr_req_d.access_length = ACCESS_LEN_WIDTH'(1);
          wr_req_d.stride_type   = NON_STRIDE;
          wr_req_d.vec_reg_ptr   = reg_q;
          wr_req_d.addr          = addr_q;
          wr_req_d.data          = lane_alu(op_q, a_q, b_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DIV: begin
        if (div_done) begin
          state_d                = S_WB;
          wr_req_d.vld           = 1'b1;
          wr_req_d.access_type   = WRITE_REQ;
          wr_req_d.access_length = ACCESS_LEN_WIDTH'(1);
          wr_req_d.stride_type   = NON_STRIDE;
          wr_req_d.vec_reg_ptr   = reg_q;
          wr_req_d.addr          = addr_q;
          wr_req_d.data          = div_quotient;
        end
      end
      S_WB: begin
        if (wr_grant) begin
          state_d  = S_IDLE;
          wr_req_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign wr_req = wr_req_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      reg_q    <= '0;
      addr_q   <= '0;
      op_q     <= SADD;
      wr_req_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      reg_q    <= reg_d;
      addr_q   <= addr_d;
      op_q     <= op_d;
      wr_req_q <= wr_req_d;
    end
  end

endmodule

// File: tb/tb_functional_lane.sv
// Directed self-checking bench for functional_lane.
module tb_functional_lane;
  import functional_lane_pkg::*;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          vld;
  logic [VECTOR_REG_WIDTH-1:0]   data0;
  logic [VECTOR_REG_WIDTH-1:0]   data1;
  logic [VREG_IDX_WIDTH-1:0]     vec_reg_in;
  logic [ADDR_FIELD_WIDTH-1:0]   vec_addr;
  function_opcode_t              functional_opcode;
  logic                          busy;
  cntrl_req_t                    wr_req;
  logic                          wr_grant;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  functional_lane #(.MUL_LATENCY(3)) dut (
    .clk               (clk),
    .reset             (reset),
    .vld               (vld),
    .data0             (data0),
    .data1             (data1),
    .vec_reg_in        (vec_reg_in),
    .vec_addr          (vec_addr),
    .functional_opcode (functional_opcode),
    .busy              (busy),
    .wr_req            (wr_req),
    .wr_grant          (wr_grant)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  function automatic cntrl_req_t exp_req(input logic [VREG_IDX_WIDTH-1:0] r,
                                         input logic [ADDR_FIELD_WIDTH-1:0] a,
                                         input logic [63:0] d);
    cntrl_req_t e;
    e               = '0;
    e.vld           = 1'b1;
    e.access_type   = WRITE_REQ;
    e.access_length = 8'd1;
    e.stride_type   = NON_STRIDE;
    e.vec_reg_ptr   = r;
    e.addr          = a;
    e.data          = d;
    return e;
  endfunction

  task automatic set_inputs(input function_opcode_t op, input logic [63:0] a, input logic [63:0] b,
                            input logic [VREG_IDX_WIDTH-1:0] r, input logic [ADDR_FIELD_WIDTH-1:0] ad);
    functional_opcode = op;
    data0             = a;
    data1             = b;
    vec_reg_in        = r;
    vec_addr          = ad;
  endtask

  // Issues one op at a negedge with grant high; returns the request seen and
  // the negedge count from issue to wr_req.vld (-1 on timeout). Ends in IDLE.
  task automatic run_op(input function_opcode_t op, input logic [63:0] a, input logic [63:0] b,
                        input logic [VREG_IDX_WIDTH-1:0] r, input logic [ADDR_FIELD_WIDTH-1:0] ad,
                        output cntrl_req_t req, output int lat);
    wr_grant = 1'b1;
    set_inputs(op, a, b, r, ad);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    lat = 1;
    while (!wr_req.vld && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    req = wr_req;
    if (!req.vld) lat = -1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    vld      = 1'b0;
    wr_grant = 1'b0;
    set_inputs(SADD, 64'd0, 64'd0, '0, '0);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if (wr_req !== cntrl_req_t'('0)) begin tests_failed++; $display("FAIL reset_wr_req: got %h want 0", wr_req); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sadd();
    cntrl_req_t e;
    wr_grant = 1'b1;
    set_inputs(SADD, 64'd5, 64'd7, 5'd3, 5'd9);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL sadd_busy_exec: got %b want 1", busy); end
    tests_run++;
    if (wr_req.vld !== 1'b0) begin tests_failed++; $display("FAIL sadd_early_vld: got %b want 0", wr_req.vld); end
    @(negedge clk);
    e = exp_req(5'd3, 5'd9, 64'd12);
    tests_run++;
    if (wr_req !== e) begin tests_failed++; $display("FAIL sadd_req: got %h want %h", wr_req, e); end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL sadd_busy_after: got %b want 0", busy); end
    tests_run++;
    if (wr_req !== cntrl_req_t'('0)) begin tests_failed++; $display("FAIL sadd_req_cleared: got %h want 0", wr_req); end
  endtask

  task automatic test_wrap();
    cntrl_req_t r;
    cntrl_req_t e;
    int lat;
    run_op(SSUB, 64'd0, 64'd1, 5'd1, 5'd2, r, lat);
    e = exp_req(5'd1, 5'd2, ALL_ONES);
    tests_run++;
    if (r !== e) begin tests_failed++; $display("FAIL ssub_wrap: got %h want %h", r, e); end
    tests_run++;
    if (lat !== 2) begin tests_failed++; $display("FAIL ssub_latency: got %0d want 2", lat); end
    run_op(SMUL, 64'h1_0000_0000, 64'h1_0000_0000, 5'd4, 5'd31, r, lat);
    e = exp_req(5'd4, 5'd31, 64'd0);
    tests_run++;
    if (r !== e) begin tests_failed++; $display("FAIL smul_wrap: got %h want %h", r, e); end
    tests_run++;
    if (lat !== 4) begin tests_failed++; $display("FAIL smul_latency: got %0d want 4", lat); end
    run_op(SMUL, 64'h1234_5678, 64'd16, 5'd6, 5'd1, r, lat);
    e = exp_req(5'd6, 5'd1, 64'h1_2345_6780);
    tests_run++;
    if (r !== e) begin tests_failed++; $display("FAIL smul_basic: got %h want %h", r, e); end
    run_op(function_opcode_t'(3'd5), 64'd10, 64'd20, 5'd7, 5'd8, r, lat);
    e = exp_req(5'd7, 5'd8, 64'd30);
    tests_run++;
    if (r !== e) begin tests_failed++; $display("FAIL bad_opcode_as_add: got %h want %h", r, e); end
    tests_run++;
    if (lat !== 2) begin tests_failed++; $display("FAIL bad_opcode_latency: got %0d want 2", lat); end
  endtask

  task automatic test_div();
    cntrl_req_t r;
    cntrl_req_t e;
    int lat;
    run_op(SDIV, 64'd100, 64'd7, 5'd10, 5'd11, r, lat);
    e = exp_req(5'd10, 5'd11, 64'd14);
    tests_run++;
    if (r !== e) begin tests_failed++; $display("FAIL sdiv_100_7: got %h want %h", r, e); end
    tests_run++;
    if (lat !== 65) begin tests_failed++; $display("FAIL sdiv_latency: got %0d want 65", lat); end
    run_op(SDIV, 64'd5, 64'd0, 5'd12, 5'd13, r, lat);
    e = exp_req(5'd12, 5'd13, ALL_ONES);
    tests_run++;
    if (r !== e) begin tests_failed++; $display("FAIL sdiv_by_zero: got %h want %h", r, e); end
    tests_run++;
    if (lat !== 65) begin tests_failed++; $display("FAIL sdiv_zero_latency: got %0d want 65", lat); end
    run_op(SDIV, ALL_ONES, 64'd3, 5'd14, 5'd15, r, lat);
    e = exp_req(5'd14, 5'd15, 64'h5555_5555_5555_5555);
    tests_run++;
    if (r !== e) begin tests_failed++; $display("FAIL sdiv_max_3: got %h want %h", r, e); end
  endtask

  task automatic test_stall();
    cntrl_req_t e;
    int waited;
    int bad;
    wr_grant = 1'b0;
    set_inputs(SMUL, 64'd3, 64'd4, 5'd5, 5'd2);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    waited = 1;
    while (!wr_req.vld && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if (waited !== 4) begin tests_failed++; $display("FAIL stall_mul_latency: got %0d want 4", waited); end
    e = exp_req(5'd5, 5'd2, 64'd12);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (wr_req !== e || busy !== 1'b1) bad++;
      if (i == 3) begin
        set_inputs(SADD, 64'd1, 64'd1, 5'd7, 5'd7);
        vld = 1'b1;
      end else begin
        vld = 1'b0;
      end
      @(negedge clk);
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL stall_hold: %0d unstable cycles, want 0 (last %h want %h)", bad, wr_req, e); end
    wr_grant = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL stall_idle_after_grant: busy %b want 0", busy); end
    tests_run++;
    if (wr_req !== cntrl_req_t'('0)) begin tests_failed++; $display("FAIL stall_req_cleared: got %h want 0", wr_req); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wr_req.vld !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL stall_ignored_vld: %0d active cycles, want 0", bad); end
  endtask

  task automatic test_back_to_back();
    cntrl_req_t e;
    wr_grant = 1'b1;
    set_inputs(SADD, 64'd1, 64'd2, 5'd1, 5'd1);
    vld = 1'b1;
    @(negedge clk);
    set_inputs(SSUB, 64'd50, 64'd8, 5'd2, 5'd3);
    @(negedge clk);
    e = exp_req(5'd1, 5'd1, 64'd3);
    tests_run++;
    if (wr_req !== e) begin tests_failed++; $display("FAIL b2b_first: got %h want %h", wr_req, e); end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || wr_req.vld !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_idle_gap: busy %b vld %b want 0 0", busy, wr_req.vld);
    end
    @(negedge clk);
    vld = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || wr_req.vld !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_second_exec: busy %b vld %b want 1 0", busy, wr_req.vld);
    end
    @(negedge clk);
    e = exp_req(5'd2, 5'd3, 64'd42);
    tests_run++;
    if (wr_req !== e) begin tests_failed++; $display("FAIL b2b_second: got %h want %h", wr_req, e); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bad;
    wr_grant = 1'b1;
    set_inputs(SDIV, 64'd1000, 64'd3, 5'd9, 5'd9);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy: got %b want 0", busy); end
    tests_run++;
    if (wr_req !== cntrl_req_t'('0)) begin tests_failed++; $display("FAIL midreset_req: got %h want 0", wr_req); end
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_req.vld !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL midreset_no_wb: %0d active cycles, want 0", bad); end
  endtask

  task automatic test_reset_release_vld();
    cntrl_req_t e;
    reset = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
    wr_grant = 1'b1;
    set_inputs(SADD, 64'd2, 64'd3, 5'd4, 5'd4);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL release_capture: busy %b want 1", busy); end
    @(negedge clk);
    e = exp_req(5'd4, 5'd4, 64'd5);
    tests_run++;
    if (wr_req !== e) begin tests_failed++; $display("FAIL release_result: got %h want %h", wr_req, e); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sadd();
    test_wrap();
    test_div();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_reset_release_vld();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
